// File: rtl/ps2_pkg.sv
// PS/2 key decoder shared definitions.
// Prefix bytes, modifier scancodes, event record, FSM states, ASCII map.
package ps2_pkg;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_PAUSE  = 8'h77;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } ps2_evt_t;

  localparam int EVT_W = $bits(ps2_evt_t);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } ps2_state_e;

  // Keyboard status/ack bytes that carry no key.
  function automatic logic is_filler(
    input logic [7:0] b
  );
    return (b == 8'hAA) || (b == 8'hFA) ||
           (b == 8'hFE) || (b == 8'hEE) ||
           (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic [7:0] ps2_ascii(
    input logic [7:0] sc,
    input logic       shift,
    input logic       caps
  );
    logic [7:0] lc;
    logic [7:0] dg;
    logic [7:0] sy;
    logic [7:0] r;
    lc = 8'h00;
    dg = 8'h00;
    sy = 8'h00;
    r  = 8'h00;
    case (sc)
      8'h1C: lc = "a";
      8'h32: lc = "b";
      8'h21: lc = "c";
      8'h23: lc = "d";
      8'h24: lc = "e";
      8'h2B: lc = "f";
      8'h34: lc = "g";
      8'h33: lc = "h";
      8'h43: lc = "i";
      8'h3B: lc = "j";
      8'h42: lc = "k";
      8'h4B: lc = "l";
      8'h3A: lc = "m";
      8'h31: lc = "n";
      8'h44: lc = "o";
      8'h4D: lc = "p";
      8'h15: lc = "q";
      8'h2D: lc = "r";
      8'h1B: lc = "s";
      8'h2C: lc = "t";
      8'h3C: lc = "u";
      8'h2A: lc = "v";
      8'h1D: lc = "w";
      8'h22: lc = "x";
      8'h35: lc = "y";
      8'h1A: lc = "z";
      default: lc = 8'h00;
    endcase
    case (sc)
      8'h16: begin dg = "1"; sy = "!"; end
      8'h1E: begin dg = "2"; sy = "@"; end
      8'h26: begin dg = "3"; sy = "#"; end
      8'h25: begin dg = "4"; sy = "$"; end
      8'h2E: begin dg = "5"; sy = "%"; end
      8'h36: begin dg = "6"; sy = "^"; end
      8'h3D: begin dg = "7"; sy = "&"; end
      8'h3E: begin dg = "8"; sy = "*"; end
      8'h46: begin dg = "9"; sy = "("; end
      8'h45: begin dg = "0"; sy = ")"; end
      default: begin dg = 8'h00; sy = 8'h00; end
    endcase
    if (lc != 8'h00)
      r = (shift ^ caps) ? (lc - 8'h20) : lc;
    else if (dg != 8'h00)
      r = shift ? sy : dg;
    else begin
      case (sc)
        8'h29:   r = 8'h20;
        8'h5A:   r = 8'h0D;
        8'h66:   r = 8'h08;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key event stream: valid/ready handshake plus decoded event fields.
// master drives the event, slave consumes it via evt_ready.
interface ps2_key_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic [7:0] evt_ascii;

  modport master (
    output evt_valid, evt_code, evt_break,
    output evt_ext, evt_ascii,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_code, evt_break,
    input  evt_ext, evt_ascii,
    output evt_ready
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO for key events; push accepted when full if popping.
// Ports: clk, rst, push_i, din_i, pop_i -> dout_o (head), full_o, empty_o.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == FULL_N);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // When full, the slot freed by a pop is the one written.
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode set-2 parser: strobe sync, prefix FSM, modifiers, FIFO.
// Ports: clk, rst, kb_byte, kb_strobe, evt (master), shift/caps, overflow.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               kb_byte,
  input  logic                     kb_strobe,
  ps2_key_decoder_if.master        evt,
  output logic                     shift_state,
  output logic                     caps_state,
  output logic                     overflow
);

  logic [2:0] sync_q;
  logic       rise;
  logic [7:0] byte_q;
  logic       cap_q;

  ps2_state_e st_q, st_d;
  logic [2:0] skip_q, skip_d;
  logic       shl_q, shl_d;
  logic       shr_q, shr_d;
  logic       caps_q, caps_d;
  logic       held_q, held_d;
  logic       ovf_q, ovf_d;

  logic       push;
  ps2_evt_t   ev;
  logic       brk;
  logic       ext;
  logic       idle;

  logic [EVT_W-1:0] head_raw;
  ps2_evt_t   head;
  logic       full;
  logic       empty;
  logic       pop;
  logic       show;

  // sync_q[1] is the synchronized strobe, sync_q[2] its history.
  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      byte_q <= '0;
      cap_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], kb_strobe};
      cap_q  <= rise;
      if (rise) byte_q <= kb_byte;
    end
  end

  assign brk  = (st_q == S_BRK) || (st_q == S_EXT_BRK);
  assign ext  = (st_q == S_EXT) || (st_q == S_EXT_BRK);
  assign idle = (st_q == S_IDLE);

  always_comb begin
    st_d   = st_q;
    skip_d = skip_q;
    shl_d  = shl_q;
    shr_d  = shr_q;
    caps_d = caps_q;
    held_d = held_q;
    push   = 1'b0;
    ev     = '0;
    if (cap_q) begin
      if (st_q == S_PAUSE) begin
        skip_d = skip_q - 1'b1;
        if (skip_d == '0) begin
          push    = 1'b1;
          ev.ext  = 1'b1;
          ev.code = SC_PAUSE;
          st_d    = S_IDLE;
        end
      end else begin
        unique case (1'b1)
          idle && (byte_q == PFX_E0):
            st_d = S_EXT;
          idle && (byte_q == PFX_F0):
            st_d = S_BRK;
          (st_q == S_EXT) && (byte_q == PFX_F0):
            st_d = S_EXT_BRK;
          idle && (byte_q == PFX_E1): begin
            st_d   = S_PAUSE;
            skip_d = PAUSE_SKIP;
          end
          idle && is_filler(byte_q): ;
          default: begin
            push    = 1'b1;
            ev.brk  = brk;
            ev.ext  = ext;
            ev.code = byte_q;
            // Modifier state used here is the pre-update value.
            if (!brk && !ext)
              ev.ascii = ps2_ascii(byte_q,
                                   shl_q | shr_q, caps_q);
            st_d = S_IDLE;
            if (!ext) begin
              if (byte_q == SC_LSHIFT) shl_d = ~brk;
              if (byte_q == SC_RSHIFT) shr_d = ~brk;
              if (byte_q == SC_CAPS) begin
                if (brk) held_d = 1'b0;
                else begin
                  if (!held_q) caps_d = ~caps_q;
                  held_d = 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign pop   = evt.evt_valid & evt.evt_ready;
  assign ovf_d = ovf_q | (push & full & ~pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q   <= S_IDLE;
      skip_q <= '0;
      shl_q  <= 1'b0;
      shr_q  <= 1'b0;
      caps_q <= 1'b0;
      held_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      skip_q <= skip_d;
      shl_q  <= shl_d;
      shr_q  <= shr_d;
      caps_q <= caps_d;
      held_q <= held_d;
      ovf_q  <= ovf_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (ev),
    .pop_i   (pop),
    .dout_o  (head_raw),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head = ps2_evt_t'(head_raw);
  // Head fields read zero while in reset or empty.
  assign show = rst & ~empty;

  assign evt.evt_valid = show;
  assign evt.evt_code  = show ? head.code  : 8'h00;
  assign evt.evt_ascii = show ? head.ascii : 8'h00;
  assign evt.evt_break = show & head.brk;
  assign evt.evt_ext   = show & head.ext;

  assign shift_state = shl_q | shr_q;
  assign caps_state  = caps_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder.
// Table of byte vectors plus latency, overflow and reset sequences.
module tb_ps2_key_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] kb_byte;
  logic       kb_strobe;
  logic       shift_state;
  logic       caps_state;
  logic       overflow;

  int n_pass;
  int n_tot;

  ps2_key_decoder_if ifc ();

  ps2_key_decoder #(.FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .kb_byte     (kb_byte),
    .kb_strobe   (kb_strobe),
    .evt         (ifc),
    .shift_state (shift_state),
    .caps_state  (caps_state),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  b;
    logic        ev;
    logic [17:0] exp;
    logic        sh;
    logic        cp;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] b);
    kb_byte   = b;
    kb_strobe = 1'b1;
    repeat (4) tick();
    kb_strobe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pop1();
    ifc.evt_ready = 1'b1;
    tick();
    ifc.evt_ready = 1'b0;
  endtask

  function automatic logic [17:0] evw();
    return {ifc.evt_break, ifc.evt_ext,
            ifc.evt_code, ifc.evt_ascii};
  endfunction

  task automatic v(input logic [7:0] b, input logic ev,
                   input logic brk, input logic ext,
                   input logic [7:0] code,
                   input logic [7:0] asc,
                   input logic sh, input logic cp);
    vec_t r;
    r.b   = b;
    r.ev  = ev;
    r.exp = {brk, ext, code, asc};
    r.sh  = sh;
    r.cp  = cp;
    tbl.push_back(r);
  endtask

  logic [7:0] ovf_codes [9];

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst = 1'b0;
    kb_byte = 8'h00;
    kb_strobe = 1'b0;
    ifc.evt_ready = 1'b0;

    // byte, ev, brk, ext, code, ascii, shift, caps
    v(8'h1C,1,0,0,8'h1C,8'h61,0,0);
    v(8'h12,1,0,0,8'h12,8'h00,1,0);
    v(8'h1C,1,0,0,8'h1C,8'h41,1,0);
    v(8'hF0,0,0,0,8'h00,8'h00,1,0);
    v(8'h1C,1,1,0,8'h1C,8'h00,1,0);
    v(8'hF0,0,0,0,8'h00,8'h00,1,0);
    v(8'h12,1,1,0,8'h12,8'h00,0,0);
    v(8'hE0,0,0,0,8'h00,8'h00,0,0);
    v(8'hF0,0,0,0,8'h00,8'h00,0,0);
    v(8'h75,1,1,1,8'h75,8'h00,0,0);
    v(8'hE1,0,0,0,8'h00,8'h00,0,0);
    v(8'h14,0,0,0,8'h00,8'h00,0,0);
    v(8'h77,0,0,0,8'h00,8'h00,0,0);
    v(8'hE1,0,0,0,8'h00,8'h00,0,0);
    v(8'hF0,0,0,0,8'h00,8'h00,0,0);
    v(8'h14,0,0,0,8'h00,8'h00,0,0);
    v(8'hF0,0,0,0,8'h00,8'h00,0,0);
    v(8'h77,1,0,1,8'h77,8'h00,0,0);
    v(8'h58,1,0,0,8'h58,8'h00,0,1);
    v(8'h58,1,0,0,8'h58,8'h00,0,1);
    v(8'hF0,0,0,0,8'h00,8'h00,0,1);
    v(8'h58,1,1,0,8'h58,8'h00,0,1);
    v(8'h58,1,0,0,8'h58,8'h00,0,0);
    v(8'h16,1,0,0,8'h16,8'h31,0,0);
    v(8'h59,1,0,0,8'h59,8'h00,1,0);
    v(8'h16,1,0,0,8'h16,8'h21,1,0);
    v(8'h1E,1,0,0,8'h1E,8'h40,1,0);
    v(8'h1A,1,0,0,8'h1A,8'h5A,1,0);
    v(8'hF0,0,0,0,8'h00,8'h00,1,0);
    v(8'h58,1,1,0,8'h58,8'h00,1,0);
    v(8'h58,1,0,0,8'h58,8'h00,1,1);
    v(8'h1A,1,0,0,8'h1A,8'h7A,1,1);
    v(8'hF0,0,0,0,8'h00,8'h00,1,1);
    v(8'h59,1,1,0,8'h59,8'h00,0,1);
    v(8'h1A,1,0,0,8'h1A,8'h5A,0,1);
    v(8'hF0,0,0,0,8'h00,8'h00,0,1);
    v(8'h58,1,1,0,8'h58,8'h00,0,1);
    v(8'h58,1,0,0,8'h58,8'h00,0,0);
    v(8'h29,1,0,0,8'h29,8'h20,0,0);
    v(8'h5A,1,0,0,8'h5A,8'h0D,0,0);
    v(8'h66,1,0,0,8'h66,8'h08,0,0);
    v(8'hAA,0,0,0,8'h00,8'h00,0,0);
    v(8'hFA,0,0,0,8'h00,8'h00,0,0);
    v(8'h00,0,0,0,8'h00,8'h00,0,0);
    v(8'hE0,0,0,0,8'h00,8'h00,0,0);
    v(8'h1C,1,0,1,8'h1C,8'h00,0,0);
    v(8'h0E,1,0,0,8'h0E,8'h00,0,0);
    v(8'h45,1,0,0,8'h45,8'h30,0,0);

    // Reset state
    repeat (2) tick();
    chk("rst_valid", ifc.evt_valid, 0);
    chk("rst_evt", evw(), 0);
    chk("rst_shift", shift_state, 0);
    chk("rst_caps", caps_state, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b1;
    tick();

    // Latency: evt_valid on 4th edge after strobe rises
    kb_byte = 8'h1C;
    kb_strobe = 1'b1;
    repeat (3) tick();
    chk("lat_valid_early", ifc.evt_valid, 0);
    tick();
    chk("lat_valid", ifc.evt_valid, 1);
    chk("lat_evt", evw(), {2'b00, 8'h1C, 8'h61});
    // Held strobe must not produce a second event
    repeat (6) tick();
    kb_strobe = 1'b0;
    repeat (3) tick();
    pop1();
    chk("lat_single", ifc.evt_valid, 0);

    // Table-driven vectors
    foreach (tbl[i]) begin
      send(tbl[i].b);
      chk($sformatf("v%0d_valid", i),
          ifc.evt_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_evt", i), evw(), tbl[i].exp);
        pop1();
      end
      chk($sformatf("v%0d_shift", i),
          shift_state, tbl[i].sh);
      chk($sformatf("v%0d_caps", i),
          caps_state, tbl[i].cp);
    end

    // Overflow: 9 makes into a depth-8 FIFO
    ovf_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                  8'h2B, 8'h34, 8'h33, 8'h43};
    for (int k = 0; k < 8; k++) send(ovf_codes[k]);
    chk("ovf_pre", overflow, 0);
    send(ovf_codes[8]);
    chk("ovf_set", overflow, 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_valid", k),
          ifc.evt_valid, 1);
      chk($sformatf("drain%0d_code", k),
          ifc.evt_code, ovf_codes[k]);
      pop1();
    end
    chk("drain_empty", ifc.evt_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Reset mid-sequence abandons the E0 prefix
    send(8'hE0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rmid_ovf", overflow, 0);
    chk("rmid_valid0", ifc.evt_valid, 0);
    send(8'h1C);
    chk("rmid_valid", ifc.evt_valid, 1);
    chk("rmid_evt", evw(), {2'b00, 8'h1C, 8'h61});
    pop1();
    chk("rmid_empty", ifc.evt_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
